// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises MEM load/store and IF fetch requests into byte
// accesses on the 8-bit RAM/IO bus and reassembles load data.
module mem_ctrl #(
    parameter logic [31:0] IO_ADDR_LO = 32'h00030000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic [31:0] mem_addr_to_read,
    input  logic [31:0] mem_data_to_write,
    input  logic [2:0]  data_len,
    output logic        mem_load_done,
    output logic [31:0] mem_ctrl_read_in,
    output logic [1:0]  mem_ctrl_busy_state,
    input  logic        if_read_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic        own_if_q, own_if_d;
    logic        mem_done_q, mem_done_d;
    logic        if_done_q, if_done_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] inst_q, inst_d;

    logic [31:0] cur_addr;
    logic        in_io;
    logic        io_stall;
    logic        load_len_ok;
    logic [1:0]  bidx;

    assign cur_addr    = base_q + {28'd0, cnt_q};
    assign in_io       = (cur_addr >= IO_ADDR_LO) && (cur_addr <= IO_ADDR_LO + 32'd7);
    assign io_stall    = (state_q == WRITE) && in_io && io_buffer_full;
    assign load_len_ok = (data_len == 3'd1) || (data_len == 3'd2) || (data_len == 3'd4);
    // Byte slot filled at this edge holds data for the address of the previous cycle.
    assign bidx        = cnt_q[1:0] - 2'd1;

    assign mem_load_done       = mem_done_q;
    assign if_done             = if_done_q;
    assign mem_ctrl_read_in    = rd_data_q;
    assign if_inst             = inst_q;
    assign mem_ctrl_busy_state = {state_q != IDLE, (state_q != IDLE) && own_if_q};

    // Bus drive: address/data for the current byte; writes gated by ready and IO stall.
    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        case (state_q)
            READ: begin
                if (cnt_q < len_q) mem_a = cur_addr;
            end
            WRITE: begin
                mem_a    = cur_addr;
                mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in && !io_stall;
            end
            default: ;
        endcase
    end

    // Next-state: accept with write > read > fetch priority, step through bytes, pulse done.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        own_if_d   = own_if_q;
        mem_done_d = 1'b0;
        if_done_d  = 1'b0;
        rd_data_d  = rd_data_q;
        inst_d     = inst_q;
        case (state_q)
            IDLE: begin
                if (write_mem) begin
                    state_d  = WRITE;
                    len_d    = {1'b0, data_len} + 4'd1;
                    base_d   = mem_addr_to_read;
                    wdata_d  = mem_data_to_write;
                    cnt_d    = 4'd0;
                    own_if_d = 1'b0;
                end else if (read_mem && load_len_ok) begin
                    state_d  = READ;
                    len_d    = {1'b0, data_len};
                    base_d   = mem_addr_to_read;
                    asm_d    = 32'd0;
                    cnt_d    = 4'd0;
                    own_if_d = 1'b0;
                end else if (if_read_req) begin
                    state_d  = READ;
                    len_d    = 4'd4;
                    base_d   = if_addr;
                    asm_d    = 32'd0;
                    cnt_d    = 4'd0;
                    own_if_d = 1'b1;
                end
            end
            READ: begin
                if (cnt_q != 4'd0) asm_d[{bidx, 3'b000} +: 8] = mem_din;
                if (cnt_q == len_q) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    if (own_if_q) begin
                        if_done_d = 1'b1;
                        inst_d    = asm_d;
                    end else begin
                        mem_done_d = 1'b1;
                        rd_data_d  = asm_d;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WRITE: begin
                if (!io_stall) begin
                    if (cnt_q == len_q - 4'd1) begin
                        state_d    = IDLE;
                        cnt_d      = 4'd0;
                        mem_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers: synchronous reset; everything frozen while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            len_q      <= 4'd0;
            own_if_q   <= 1'b0;
            mem_done_q <= 1'b0;
            if_done_q  <= 1'b0;
            rd_data_q  <= 32'd0;
            inst_q     <= 32'd0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            own_if_q   <= own_if_d;
            mem_done_q <= mem_done_d;
            if_done_q  <= if_done_d;
            rd_data_q  <= rd_data_d;
            inst_q     <= inst_d;
        end
    end

    // Datapath registers: address, store data and assembly buffer need no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            base_q  <= base_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed-vector bench for mem_ctrl with a byte RAM model.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        read_mem;
    logic        write_mem;
    logic [31:0] mem_addr_to_read;
    logic [31:0] mem_data_to_write;
    logic [2:0]  data_len;
    logic        mem_load_done;
    logic [31:0] mem_ctrl_read_in;
    logic [1:0]  mem_ctrl_busy_state;
    logic        if_read_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:1023];
    int          wcnt [0:1023];
    logic        pre_we;
    logic [9:0]  pre_a;
    logic [7:0]  pre_d;

    int n_tests = 0;
    int n_fail  = 0;

    mem_ctrl dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .read_mem            (read_mem),
        .write_mem           (write_mem),
        .mem_addr_to_read    (mem_addr_to_read),
        .mem_data_to_write   (mem_data_to_write),
        .data_len            (data_len),
        .mem_load_done       (mem_load_done),
        .mem_ctrl_read_in    (mem_ctrl_read_in),
        .mem_ctrl_busy_state (mem_ctrl_busy_state),
        .if_read_req         (if_read_req),
        .if_addr             (if_addr),
        .if_done             (if_done),
        .if_inst             (if_inst),
        .mem_din             (mem_din),
        .mem_dout            (mem_dout),
        .mem_a               (mem_a),
        .mem_wr              (mem_wr),
        .io_buffer_full      (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: one-cycle read latency, byte writes, per-address write counts.
    always @(posedge clk_in) begin
        if (pre_we) begin
            ram[pre_a] <= pre_d;
        end else if (mem_wr) begin
            ram[mem_a[9:0]]  <= mem_dout;
            wcnt[mem_a[9:0]] <= wcnt[mem_a[9:0]] + 1;
        end
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        tick();
        pre_we = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; read_mem = 1'b0; write_mem = 1'b0;
        mem_addr_to_read = 32'd0; mem_data_to_write = 32'd0; data_len = 3'd0;
        if_read_req = 1'b0; if_addr = 32'd0; io_buffer_full = 1'b0;
        pre_we = 1'b0; pre_a = 10'd0; pre_d = 8'd0;

        // Reset and RAM preload
        tick();
        preload(10'h100, 8'h11); preload(10'h101, 8'h22);
        preload(10'h102, 8'h33); preload(10'h103, 8'h44);
        preload(10'h200, 8'h5A); preload(10'h201, 8'hA5);
        preload(10'h300, 8'h13); preload(10'h301, 8'h00);
        preload(10'h302, 8'h00); preload(10'h303, 8'h93);
        check("rst_done",   {31'd0, mem_load_done}, 32'd0);
        check("rst_ifdone", {31'd0, if_done}, 32'd0);
        check("rst_rdata",  mem_ctrl_read_in, 32'd0);
        check("rst_inst",   if_inst, 32'd0);
        check("rst_busy",   {30'd0, mem_ctrl_busy_state}, 32'd0);
        check("rst_bus",    {mem_a[22:0], mem_dout, mem_wr}, 32'd0);
        rst_in = 1'b0;
        tick();

        // LW at 0x100
        read_mem = 1'b1; mem_addr_to_read = 32'h100; data_len = 3'd4;
        tick();
        read_mem = 1'b0;
        check("lw_busy", {30'd0, mem_ctrl_busy_state}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("lw_addr", mem_a, 32'h100 + i);
            check("lw_wr",   {31'd0, mem_wr}, 32'd0);
            tick();
        end
        check("lw_addr_end", mem_a, 32'd0);
        check("lw_done_early", {31'd0, mem_load_done}, 32'd0);
        tick();
        check("lw_done", {31'd0, mem_load_done}, 32'd1);
        check("lw_data", mem_ctrl_read_in, 32'h44332211);
        check("lw_busy_idle", {30'd0, mem_ctrl_busy_state}, 32'd0);
        tick();
        check("lw_done_pulse", {31'd0, mem_load_done}, 32'd0);

        // SB at 0x20
        write_mem = 1'b1; mem_addr_to_read = 32'h20; mem_data_to_write = 32'hAABBCCDD; data_len = 3'd0;
        tick();
        write_mem = 1'b0;
        check("sb_addr", mem_a, 32'h20);
        check("sb_dout", {24'd0, mem_dout}, 32'hDD);
        check("sb_wr",   {31'd0, mem_wr}, 32'd1);
        check("sb_done_early", {31'd0, mem_load_done}, 32'd0);
        tick();
        check("sb_done", {31'd0, mem_load_done}, 32'd1);
        tick();

        // SW at 0x40
        write_mem = 1'b1; mem_addr_to_read = 32'h40; mem_data_to_write = 32'hAABBCCDD; data_len = 3'd3;
        tick();
        write_mem = 1'b0;
        check("sw_b0", {mem_a[23:0], mem_dout}, {24'h40, 8'hDD});
        tick();
        check("sw_b1", {mem_a[23:0], mem_dout}, {24'h41, 8'hCC});
        tick();
        check("sw_b2", {mem_a[23:0], mem_dout}, {24'h42, 8'hBB});
        tick();
        check("sw_b3", {mem_a[23:0], mem_dout}, {24'h43, 8'hAA});
        check("sw_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        check("sw_done", {31'd0, mem_load_done}, 32'd1);
        check("sw_ram", {24'd0, ram[10'h43]}, 32'hAA);
        tick();

        // LH and IF fetch requested together
        read_mem = 1'b1; mem_addr_to_read = 32'h200; data_len = 3'd2;
        if_read_req = 1'b1; if_addr = 32'h300;
        tick();
        read_mem = 1'b0;
        check("lh_busy", {30'd0, mem_ctrl_busy_state}, 32'd2);
        tick(); tick(); tick();
        check("lh_done", {31'd0, mem_load_done}, 32'd1);
        check("lh_data", mem_ctrl_read_in, 32'h0000A55A);
        check("lh_ifdone", {31'd0, if_done}, 32'd0);
        tick();
        if_read_req = 1'b0;
        check("if_busy", {30'd0, mem_ctrl_busy_state}, 32'd3);
        check("if_addr0", mem_a, 32'h300);
        tick(); tick(); tick(); tick();
        check("if_done_early", {31'd0, if_done}, 32'd0);
        tick();
        check("if_done", {31'd0, if_done}, 32'd1);
        check("if_inst", if_inst, 32'h93000013);
        check("if_memdone", {31'd0, mem_load_done}, 32'd0);
        tick();

        // SB to IO window with sink full for 3 cycles
        io_buffer_full = 1'b1;
        write_mem = 1'b1; mem_addr_to_read = 32'h00030000; mem_data_to_write = 32'h00000077; data_len = 3'd0;
        tick();
        write_mem = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("io_stall_wr", {31'd0, mem_wr}, 32'd0);
            check("io_stall_a",  mem_a, 32'h00030000);
            tick();
        end
        check("io_done_early", {31'd0, mem_load_done}, 32'd0);
        io_buffer_full = 1'b0;
        #1;
        check("io_wr", {31'd0, mem_wr}, 32'd1);
        check("io_dout", {24'd0, mem_dout}, 32'h77);
        tick();
        check("io_done", {31'd0, mem_load_done}, 32'd1);
        tick();

        // Reset mid-LW, then a fresh LB
        read_mem = 1'b1; mem_addr_to_read = 32'h100; data_len = 3'd4;
        tick();
        read_mem = 1'b0;
        tick(); tick();
        check("rlw_addr_c2", mem_a, 32'h102);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("rlw_busy", {30'd0, mem_ctrl_busy_state}, 32'd0);
        check("rlw_done", {31'd0, mem_load_done}, 32'd0);
        check("rlw_a", mem_a, 32'd0);
        tick(); tick(); tick();
        check("rlw_nodone", {31'd0, mem_load_done}, 32'd0);
        read_mem = 1'b1; mem_addr_to_read = 32'h102; data_len = 3'd1;
        tick();
        read_mem = 1'b0;
        check("lb_busy", {30'd0, mem_ctrl_busy_state}, 32'd2);
        tick(); tick();
        check("lb_done", {31'd0, mem_load_done}, 32'd1);
        check("lb_data", mem_ctrl_read_in, 32'h00000033);
        tick();

        // SW with rdy_in low for 2 cycles mid-transaction
        write_mem = 1'b1; mem_addr_to_read = 32'h80; mem_data_to_write = 32'h04030201; data_len = 3'd3;
        tick();
        write_mem = 1'b0;
        check("rdy_b0", {24'd0, mem_dout}, 32'h01);
        tick();
        check("rdy_b1", {24'd0, mem_dout}, 32'h02);
        rdy_in = 1'b0;
        #1;
        check("rdy_wr_low", {31'd0, mem_wr}, 32'd0);
        tick();
        check("rdy_frozen1", {mem_a[23:0], mem_dout}, {24'h81, 8'h02});
        check("rdy_wr_low2", {31'd0, mem_wr}, 32'd0);
        tick();
        check("rdy_frozen2", {mem_a[23:0], mem_dout}, {24'h81, 8'h02});
        rdy_in = 1'b1;
        #1;
        check("rdy_wr_back", {31'd0, mem_wr}, 32'd1);
        tick();
        check("rdy_b2", {24'd0, mem_dout}, 32'h03);
        tick();
        check("rdy_b3", {24'd0, mem_dout}, 32'h04);
        tick();
        check("rdy_done", {31'd0, mem_load_done}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("rdy_ram",  {24'd0, ram[10'h80 + i[9:0]]}, i + 1);
            check("rdy_wcnt", wcnt[10'h80 + i], 32'd1);
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
